// File: rtl/store_commit_unit.sv
// rtl/store_commit_unit.sv - in-order store issue from store FIFO head to data memory
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   sq_empty, sq_ready              store FIFO head status
//   sq_rs1_val, sq_rs2_val, sq_imm  base, store data and S-type immediate of FIFO head
//   sq_funct3, sq_rob_idx           store width (SB/SH/SW) and ROB index of FIFO head
//   sq_ren                          FIFO pop, combinational in the acceptance cycle
//   rob_head_valid, rob_head_idx    ROB head entry
//   dmem_req/addr/wmask/wdata       registered write request, held until dmem_resp
//   dmem_resp                       memory write acknowledge
//   st_done, st_done_rob_idx        one-cycle completion pulse with ROB index
//   st_done_exc                     completion carries a misaligned/illegal exception
//   st_err                          sticky response-timeout flag
module store_commit_unit #(
    parameter int ROB_IDX_W   = 5,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sq_empty,
    input  logic                 sq_ready,
    input  logic [31:0]          sq_rs1_val,
    input  logic [31:0]          sq_rs2_val,
    input  logic [31:0]          sq_imm,
    input  logic [2:0]           sq_funct3,
    input  logic [ROB_IDX_W-1:0] sq_rob_idx,
    output logic                 sq_ren,
    input  logic                 rob_head_valid,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    output logic                 dmem_req,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_resp,
    output logic                 st_done,
    output logic [ROB_IDX_W-1:0] st_done_rob_idx,
    output logic                 st_done_exc,
    output logic                 st_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [ROB_IDX_W-1:0]   rob_q;
    logic                   exc_q;

    logic                   accept;
    logic [31:0]            ea;
    logic                   aligned;
    logic [3:0]             lane_mask;
    logic [31:0]            lane_data;

    assign accept = !sq_empty && sq_ready && rob_head_valid && (sq_rob_idx == rob_head_idx);
    assign ea     = sq_rs1_val + sq_imm;

    // Lane placement: narrow stores replicate their data across the word so the
    // byte mask alone selects which lanes memory actually writes.
    always_comb begin
        aligned   = 1'b0;
        lane_mask = 4'b0000;
        lane_data = sq_rs2_val;
        case (sq_funct3)
            3'b000: begin
                aligned   = 1'b1;
                lane_mask = 4'b0001 << ea[1:0];
                lane_data = {4{sq_rs2_val[7:0]}};
            end
            3'b001: begin
                aligned   = !ea[0];
                lane_mask = 4'b0011 << ea[1:0];
                lane_data = {2{sq_rs2_val[15:0]}};
            end
            3'b010: begin
                aligned   = (ea[1:0] == 2'b00);
                lane_mask = 4'hF;
                lane_data = sq_rs2_val;
            end
            default: aligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sq_ren    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sq_ren    = 1'b1;
                    state_nxt = aligned ? REQ : DONE;
                end
            end
            REQ: begin
                if (dmem_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt         <= '0;
            rob_q           <= '0;
            exc_q           <= 1'b0;
            dmem_req        <= 1'b0;
            dmem_addr       <= '0;
            dmem_wmask      <= '0;
            dmem_wdata      <= '0;
            st_done         <= 1'b0;
            st_done_rob_idx <= '0;
            st_done_exc     <= 1'b0;
            st_err          <= 1'b0;
        end else begin
            st_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rob_q <= sq_rob_idx;
                        exc_q <= !aligned;
                        if (aligned) begin
                            dmem_req   <= 1'b1;
                            dmem_addr  <= {ea[31:2], 2'b00};
                            dmem_wmask <= lane_mask;
                            dmem_wdata <= lane_data;
                        end
                    end
                end
                REQ: begin
                    if (dmem_resp) begin
                        dmem_req <= 1'b0;
                        exc_q    <= 1'b0;
                        tmo_cnt  <= '0;
                    end else begin
                        // Counter saturates; the request stays up regardless.
                        if (tmo_cnt != TMO_MAX) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                        if (tmo_cnt == TMO_LAST) begin
                            st_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    st_done         <= 1'b1;
                    st_done_rob_idx <= rob_q;
                    st_done_exc     <= exc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_commit_unit.sv
// tb/tb_store_commit_unit.sv - directed self-checking bench for store_commit_unit
module tb_store_commit_unit;

    logic        clk;
    logic        rst_n;
    logic        sq_empty;
    logic        sq_ready;
    logic [31:0] sq_rs1_val;
    logic [31:0] sq_rs2_val;
    logic [31:0] sq_imm;
    logic [2:0]  sq_funct3;
    logic [4:0]  sq_rob_idx;
    logic        sq_ren;
    logic        rob_head_valid;
    logic [4:0]  rob_head_idx;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic        st_done;
    logic [4:0]  st_done_rob_idx;
    logic        st_done_exc;
    logic        st_err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;

    store_commit_unit #(
        .ROB_IDX_W  (5),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sq_empty       (sq_empty),
        .sq_ready       (sq_ready),
        .sq_rs1_val     (sq_rs1_val),
        .sq_rs2_val     (sq_rs2_val),
        .sq_imm         (sq_imm),
        .sq_funct3      (sq_funct3),
        .sq_rob_idx     (sq_rob_idx),
        .sq_ren         (sq_ren),
        .rob_head_valid (rob_head_valid),
        .rob_head_idx   (rob_head_idx),
        .dmem_req       (dmem_req),
        .dmem_addr      (dmem_addr),
        .dmem_wmask     (dmem_wmask),
        .dmem_wdata     (dmem_wdata),
        .dmem_resp      (dmem_resp),
        .st_done        (st_done),
        .st_done_rob_idx(st_done_rob_idx),
        .st_done_exc    (st_done_exc),
        .st_err         (st_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (st_done) done_cnt = done_cnt + 1;
        if (dmem_req) req_cnt = req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2, input logic [4:0] idx);
        sq_empty   = 1'b0;
        sq_ready   = 1'b1;
        sq_funct3  = f3;
        sq_rs1_val = rs1;
        sq_imm     = imm;
        sq_rs2_val = rs2;
        sq_rob_idx = idx;
    endtask

    task automatic idle_inputs();
        sq_empty = 1'b1;
        sq_ready = 1'b0;
    endtask

    // Accept one store with an immediate response and check the full handshake.
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] idx,
                             input logic exp_exc, input logic [31:0] exp_addr,
                             input logic [3:0] exp_mask, input logic [31:0] exp_data);
        int d0;
        int r0;
        rob_head_idx = idx;
        load(f3, rs1, imm, rs2, idx);
        #1;
        check({tag, "_ren"}, 32'(sq_ren), 32'd1);
        d0 = done_cnt;
        r0 = req_cnt;
        tick();
        idle_inputs();
        if (!exp_exc) begin
            check({tag, "_req"}, 32'(dmem_req), 32'd1);
            check({tag, "_addr"}, dmem_addr, exp_addr);
            check({tag, "_mask"}, 32'(dmem_wmask), 32'(exp_mask));
            check({tag, "_data"}, dmem_wdata, exp_data);
            dmem_resp = 1'b1;
            tick();
            dmem_resp = 1'b0;
            check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
            check({tag, "_done_early"}, 32'(st_done), 32'd0);
        end else begin
            check({tag, "_noreq"}, 32'(dmem_req), 32'd0);
            check({tag, "_done_early"}, 32'(st_done), 32'd0);
        end
        tick();
        check({tag, "_done"}, 32'(st_done), 32'd1);
        check({tag, "_idx"}, 32'(st_done_rob_idx), 32'(idx));
        check({tag, "_exc"}, 32'(st_done_exc), 32'(exp_exc));
        tick();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        if (exp_exc) check({tag, "_no_mem"}, 32'(req_cnt - r0), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n          = 1'b0;
        sq_empty       = 1'b1;
        sq_ready       = 1'b0;
        sq_rs1_val     = '0;
        sq_rs2_val     = '0;
        sq_imm         = '0;
        sq_funct3      = '0;
        sq_rob_idx     = '0;
        rob_head_valid = 1'b1;
        rob_head_idx   = '0;
        dmem_resp      = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_done", 32'(st_done), 32'd0);
        check("rst_err", 32'(st_err), 32'd0);
        check("rst_ren", 32'(sq_ren), 32'd0);
        rst_n = 1'b1;
        tick();

        run_store("sb", 3'b000, 32'h0000_1000, 32'd3, 32'h0000_12AB, 5'd1, 1'b0,
                  32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
        run_store("sh_mis", 3'b001, 32'h0000_2000, 32'd1, 32'h0000_5555, 5'd2, 1'b1,
                  32'h0, 4'h0, 32'h0);
        run_store("sh", 3'b001, 32'h0000_3000, 32'd2, 32'h1234_ABCD, 5'd3, 1'b0,
                  32'h0000_3000, 4'b1100, 32'hABCD_ABCD);
        run_store("illegal", 3'b011, 32'h0000_4000, 32'd0, 32'h1, 5'd9, 1'b1,
                  32'h0, 4'h0, 32'h0);

        // Order and readiness gating
        rob_head_idx = 5'd3;
        load(3'b000, 32'h0, 32'h0, 32'h0, 5'd4);
        #1;
        check("gate_order", 32'(sq_ren), 32'd0);
        tick();
        check("gate_order_req", 32'(dmem_req), 32'd0);
        rob_head_idx = 5'd4;
        #1;
        check("gate_match", 32'(sq_ren), 32'd1);
        tick();
        idle_inputs();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        tick();
        tick();
        rob_head_idx = 5'd5;
        load(3'b000, 32'h0, 32'h0, 32'h0, 5'd5);
        sq_ready = 1'b0;
        #1;
        check("gate_ready", 32'(sq_ren), 32'd0);
        tick();
        check("gate_ready_req", 32'(dmem_req), 32'd0);
        idle_inputs();

        // Held request with address wrap; response after 5 cycles also exercises timeout
        rob_head_idx = 5'd6;
        load(3'b010, 32'hFFFF_FFFC, 32'd8, 32'hDEAD_BEEF, 5'd6);
        #1;
        check("held_ren", 32'(sq_ren), 32'd1);
        d0 = done_cnt;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("held_req", 32'(dmem_req), 32'd1);
            check("held_addr", dmem_addr, 32'h0000_0004);
            check("held_mask", 32'(dmem_wmask), 32'hF);
            check("held_data", dmem_wdata, 32'hDEAD_BEEF);
            check("held_no_ren", 32'(sq_ren), 32'd0);
            if (i == 3) check("tmo_err_pre", 32'(st_err), 32'd0);
            if (i == 4) check("tmo_err_set", 32'(st_err), 32'd1);
            tick();
        end
        check("tmo_req_still", 32'(dmem_req), 32'd1);
        idle_inputs();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("held_req_drop", 32'(dmem_req), 32'd0);
        tick();
        check("held_done", 32'(st_done), 32'd1);
        check("held_idx", 32'(st_done_rob_idx), 32'd6);
        check("held_exc", 32'(st_done_exc), 32'd0);
        tick();
        check("held_done_once", 32'(done_cnt - d0), 32'd1);
        check("tmo_err_sticky", 32'(st_err), 32'd1);

        // Reset while a request is outstanding
        rob_head_idx = 5'd7;
        load(3'b000, 32'h0000_0010, 32'd0, 32'h55, 5'd7);
        tick();
        idle_inputs();
        check("rr_req", 32'(dmem_req), 32'd1);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rr_req_async", 32'(dmem_req), 32'd0);
        check("rr_err_clr", 32'(st_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rr_no_done", 32'(done_cnt - d0), 32'd0);
        run_store("post_rst", 3'b010, 32'h0000_0100, 32'd4, 32'hCAFE_F00D, 5'd8, 1'b0,
                  32'h0000_0104, 4'hF, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
